// File: rtl/rs_erasure_decoder_pipe_if.sv
// Codeword request/response bundle for rs_erasure_decoder_pipe.
// slave = decoder side, master = upstream/downstream side.
interface rs_erasure_decoder_pipe_if #(
  parameter int unsigned NUM_DATA_SYM = 8
);
  localparam int unsigned N = NUM_DATA_SYM + 2;

  logic                      in_valid;
  logic                      in_ready;
  logic [8*N-1:0]            codeword_in;
  logic [N-1:0]              erasure_mask_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [8*NUM_DATA_SYM-1:0] data_out;
  logic [1:0]                decode_result_out;

  modport master (
    output in_valid, codeword_in, erasure_mask_in, out_ready,
    input  in_ready, out_valid, data_out, decode_result_out
  );

  modport slave (
    input  in_valid, codeword_in, erasure_mask_in, out_ready,
    output in_ready, out_valid, data_out, decode_result_out
  );
endinterface

// File: rtl/rs_erasure_decoder_pipe.sv
// Two-stage RS(K+2,K) GF(2^8) error/erasure decoder with valid/ready flow control.
// Optional two-erasure solver is compiled in when RS_DEC_DOUBLE_ERASURE_EN is defined.
module rs_erasure_decoder_pipe #(
  parameter int unsigned NUM_DATA_SYM = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  rs_erasure_decoder_pipe_if.slave bus,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         ce_cnt,
  output logic [CNT_W-1:0]         due_cnt
);
  localparam int unsigned K = NUM_DATA_SYM;
  localparam int unsigned N = K + 2;
  localparam logic [1:0] RES_NE = 2'b00, RES_CE = 2'b01, RES_DUE = 2'b10;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_alpha_pow(input int unsigned n);
    logic [7:0] x;
    x = 8'h01;
    for (int unsigned k = 0; k < n; k++) x = gf_mul(x, 8'h02);
    return x;
  endfunction

`ifdef RS_DEC_DOUBLE_ERASURE_EN
  // a^-1 = a^254 = a^2 * a^4 * ... * a^128
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction
`endif

  logic [7:0] w_alpha [K];
  for (genvar g = 0; g < K; g++) begin : g_alpha
    assign w_alpha[g] = gf_alpha_pow(g);
  end

  logic           r_s1_valid, r_out_valid;
  logic [8*K-1:0] r_cw_data, r_data;
  logic [N-1:0]   r_mask;
  logic [7:0]     r_s0, r_s1;
  logic [5:0]     r_e;
  logic [1:0]     r_res;
  logic [CNT_W-1:0] r_ce, r_due;

  logic w_s2_ready, w_s1_ready, w_in_hs, w_out_hs;
  assign w_s2_ready   = !r_out_valid || bus.out_ready;
  assign w_s1_ready   = !r_s1_valid || w_s2_ready;
  assign bus.in_ready = !rst && w_s1_ready;
  assign w_in_hs      = bus.in_valid && bus.in_ready;
  assign w_out_hs     = r_out_valid && bus.out_ready;

  // Stage-1 syndromes and erasure count
  logic [7:0] w_s0, w_s1;
  logic [5:0] w_e;
  always_comb begin
    w_s0 = bus.codeword_in[15:8];
    w_s1 = bus.codeword_in[7:0];
    w_e  = '0;
    for (int i = 0; i < K; i++) begin
      w_s0 = w_s0 ^ bus.codeword_in[8*(N-i)-1 -: 8];
      w_s1 = w_s1 ^ gf_mul(w_alpha[i], bus.codeword_in[8*(N-i)-1 -: 8]);
    end
    for (int i = 0; i < N; i++) w_e = w_e + {5'd0, bus.erasure_mask_in[i]};
  end

  // Stage-2 decode; mask bit N-1-i flags symbol i
  logic [8*K-1:0] w_data;
  logic [1:0]     w_res;
  logic [5:0]     w_pos_a;
  logic           w_found, w_h0a, w_zero;
  logic [7:0]     w_h1a;
`ifdef RS_DEC_DOUBLE_ERASURE_EN
  logic [5:0]     w_pos_b;
  logic           w_h0b;
  logic [7:0]     w_h1b, w_det, w_inv, w_ea, w_eb;
`endif
  always_comb begin
    w_data  = r_cw_data;
    w_res   = RES_DUE;
    w_pos_a = '0;
    w_found = 1'b0;
`ifdef RS_DEC_DOUBLE_ERASURE_EN
    w_pos_b = '0;
    w_det   = '0;
    w_inv   = '0;
    w_ea    = '0;
    w_eb    = '0;
`endif
    for (int i = 0; i < N; i++) begin
      if (r_mask[N-1-i]) begin
        if (!w_found) begin
          w_pos_a = 6'(i);
          w_found = 1'b1;
        end
`ifdef RS_DEC_DOUBLE_ERASURE_EN
        else w_pos_b = 6'(i);
`endif
      end
    end
    w_h0a = (w_pos_a != 6'(K+1));
    w_h1a = (w_pos_a == 6'(K+1)) ? 8'h01 : 8'h00;
`ifdef RS_DEC_DOUBLE_ERASURE_EN
    w_h0b = (w_pos_b != 6'(K+1));
    w_h1b = (w_pos_b == 6'(K+1)) ? 8'h01 : 8'h00;
`endif
    for (int k = 0; k < K; k++) begin
      if (w_pos_a == 6'(k)) w_h1a = w_alpha[k];
`ifdef RS_DEC_DOUBLE_ERASURE_EN
      if (w_pos_b == 6'(k)) w_h1b = w_alpha[k];
`endif
    end
    w_zero = (r_s0 == 8'h00) && (r_s1 == 8'h00);

    if (r_e == 6'd0) begin
      if (w_zero) w_res = RES_NE;
      else if (r_s0 == 8'h00 || r_s1 == 8'h00) w_res = RES_CE;  // lone parity error
      else begin
        for (int j = 0; j < K; j++) begin
          if (gf_mul(w_alpha[j], r_s0) == r_s1) begin
            w_data[8*(K-j)-1 -: 8] = w_data[8*(K-j)-1 -: 8] ^ r_s0;
            w_res = RES_CE;
          end
        end
      end
    end else if (r_e == 6'd1) begin
      if (w_zero) w_res = RES_NE;
      else if (w_h0a ? (r_s1 == gf_mul(w_h1a, r_s0)) : (r_s0 == 8'h00)) begin
        w_res = RES_CE;
        for (int k = 0; k < K; k++) begin
          if (w_pos_a == 6'(k)) w_data[8*(K-k)-1 -: 8] = w_data[8*(K-k)-1 -: 8] ^ r_s0;
        end
      end
    end
`ifdef RS_DEC_DOUBLE_ERASURE_EN
    else if (r_e == 6'd2) begin
      w_det = (w_h0a ? w_h1b : 8'h00) ^ (w_h0b ? w_h1a : 8'h00);
      w_inv = gf_inv(w_det);
      w_ea  = gf_mul(w_inv, gf_mul(r_s0, w_h1b) ^ (w_h0b ? r_s1 : 8'h00));
      w_eb  = gf_mul(w_inv, (w_h0a ? r_s1 : 8'h00) ^ gf_mul(w_h1a, r_s0));
      if (w_ea == 8'h00 && w_eb == 8'h00) w_res = RES_NE;
      else begin
        w_res = RES_CE;
        for (int k = 0; k < K; k++) begin
          if (w_pos_a == 6'(k)) w_data[8*(K-k)-1 -: 8] = w_data[8*(K-k)-1 -: 8] ^ w_ea;
          if (w_pos_b == 6'(k)) w_data[8*(K-k)-1 -: 8] = w_data[8*(K-k)-1 -: 8] ^ w_eb;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_cw_data   <= '0;
      r_mask      <= '0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_e         <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_res       <= RES_NE;
      r_ce        <= '0;
      r_due       <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= w_in_hs;
        if (w_in_hs) begin
          r_cw_data <= bus.codeword_in[8*N-1 -: 8*K];
          r_mask    <= bus.erasure_mask_in;
          r_s0      <= w_s0;
          r_s1      <= w_s1;
          r_e       <= w_e;
        end
      end
      if (w_s2_ready) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_data <= w_data;
          r_res  <= w_res;
        end
      end
      if (cnt_clr) begin
        r_ce  <= '0;
        r_due <= '0;
      end else if (w_out_hs) begin
        if (r_res == RES_CE && r_ce != '1) r_ce <= r_ce + CNT_W'(1);
        if (r_res == RES_DUE && r_due != '1) r_due <= r_due + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid         = r_out_valid;
  assign bus.data_out          = r_data;
  assign bus.decode_result_out = r_res;
  assign ce_cnt                = r_ce;
  assign due_cnt               = r_due;
endmodule

// File: tb/tb_rs_erasure_decoder_pipe.sv
// Directed scoreboard bench for rs_erasure_decoder_pipe (K=8, CNT_W=4).
module tb_rs_erasure_decoder_pipe;
  localparam int unsigned K  = 8;
  localparam int unsigned N  = K + 2;
  localparam int unsigned CW = 4;
  localparam logic [1:0] NE = 2'b00, CE = 2'b01, DUE = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cnt_clr = 1'b0;
  logic [CW-1:0] ce_cnt, due_cnt;

  rs_erasure_decoder_pipe_if #(.NUM_DATA_SYM(K)) bus ();

  rs_erasure_decoder_pipe #(.NUM_DATA_SYM(K), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .ce_cnt  (ce_cnt),
    .due_cnt (due_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8*K-1:0] data;
    logic [1:0]     res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  logic [CW-1:0] m_ce = '0, m_due = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Polynomial product then reduction by x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] apow(input int n);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < n; i++) x = tmul(x, 8'h02);
    return x;
  endfunction

  function automatic logic [8*N-1:0] encode(input logic [8*K-1:0] d);
    logic [7:0] p0, p1, s;
    p0 = '0;
    p1 = '0;
    for (int i = 0; i < K; i++) begin
      s  = d[8*(K-i)-1 -: 8];
      p0 = p0 ^ s;
      p1 = p1 ^ tmul(apow(i), s);
    end
    return {d, p0, p1};
  endfunction

  function automatic logic [8*N-1:0] flip(input logic [8*N-1:0] cw, input int pos,
                                          input logic [7:0] e);
    cw[8*(N-pos)-1 -: 8] = cw[8*(N-pos)-1 -: 8] ^ e;
    return cw;
  endfunction

  function automatic logic [N-1:0] mb(input int pos);
    logic [N-1:0] m;
    m = '0;
    m[N-1-pos] = 1'b1;
    return m;
  endfunction

  task automatic send(input logic [8*N-1:0] cw, input logic [N-1:0] m,
                      input logic [8*K-1:0] ed, input logic [1:0] er);
    int n;
    n = 0;
    bus.in_valid        = 1'b1;
    bus.codeword_in     = cw;
    bus.erasure_mask_in = m;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready) sb.push_back(exp_t'({ed, er}));
    else chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #2;
  endtask

  // Output monitor and counter model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_ce  = '0;
      m_due = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("data_out", bus.data_out, mon_e.data);
          chk("result", {62'd0, bus.decode_result_out}, {62'd0, mon_e.res});
        end
      end
      if (cnt_clr) begin
        m_ce  = '0;
        m_due = '0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (bus.decode_result_out == CE && m_ce != '1) m_ce++;
        if (bus.decode_result_out == DUE && m_due != '1) m_due++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [8*K-1:0] d0, rd;
  logic [8*N-1:0] cw0;
  logic [8*K-1:0] dr [4];
  logic [8*N-1:0] wr [4];

  initial begin
    bus.in_valid = 1'b0;
    bus.codeword_in = '0;
    bus.erasure_mask_in = '0;
    bus.out_ready = 1'b1;
    d0  = 64'h0102030405060708;
    cw0 = encode(d0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data_out", bus.data_out, 64'd0);
    chk("rst_result", {62'd0, bus.decode_result_out}, 64'd0);
    chk("rst_ce_cnt", {60'd0, ce_cnt}, 64'd0);
    chk("rst_due_cnt", {60'd0, due_cnt}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // All-zero codeword: NE and two-cycle latency
    send('0, '0, '0, NE);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("latency_cycle1", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_cycle2", {63'd0, bus.out_valid}, 64'd1);
    drain();
    chk("ne_ce_cnt", {60'd0, ce_cnt}, 64'd0);
    chk("ne_due_cnt", {60'd0, due_cnt}, 64'd0);

    // Single data error, no erasures
    send(flip(cw0, 3, 8'h5A), '0, d0, CE);
    drain();
    chk("ce1_ce_cnt", {60'd0, ce_cnt}, 64'd1);

    // Two erasures at symbols 1 and 6
`ifdef RS_DEC_DOUBLE_ERASURE_EN
    send(flip(flip(cw0, 1, 8'hFD), 6, 8'h16), mb(1) | mb(6), d0, CE);
    drain();
    chk("e2_ce_cnt", {60'd0, ce_cnt}, 64'd2);
    chk("e2_due_cnt", {60'd0, due_cnt}, 64'd0);
`else
    send(flip(flip(cw0, 1, 8'hFD), 6, 8'h16), mb(1) | mb(6), 64'h01FF030405061108, DUE);
    drain();
    chk("e2_ce_cnt", {60'd0, ce_cnt}, 64'd1);
    chk("e2_due_cnt", {60'd0, due_cnt}, 64'd1);
`endif

    // Back-to-back mix of error/erasure cases
    send(flip(cw0, 2, 8'h01), mb(2) | mb(4) | mb(9), 64'h0102020405060708, DUE);
    send(flip(flip(cw0, 0, 8'h01), 1, 8'h02), '0, 64'h0000030405060708, DUE);
    send(flip(cw0, 4, 8'h33), mb(4), d0, CE);
    send(flip(cw0, 8, 8'h77), mb(8), d0, CE);
    send(flip(cw0, 2, 8'h10), mb(9), 64'h0102130405060708, DUE);
    send(flip(cw0, 5, 8'h21), mb(2), 64'h0102030405270708, DUE);
    send(cw0, '0, d0, NE);
    send(cw0, mb(3), d0, NE);
    send(flip(cw0, 9, 8'h44), '0, d0, CE);
    drain();
    chk("mix_ce_cnt", {60'd0, ce_cnt}, {60'd0, m_ce});
    chk("mix_due_cnt", {60'd0, due_cnt}, {60'd0, m_due});

    // Backpressure: two accepted, then in_ready low and outputs held
    for (int k = 0; k < 4; k++) begin
      dr[k] = {$urandom, $urandom};
      wr[k] = flip(encode(dr[k]), k, 8'h01 << k);
    end
    bus.out_ready = 1'b0;
    send(wr[0], '0, dr[0], CE);
    send(wr[1], '0, dr[1], CE);
    bus.codeword_in = wr[2];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_hold_data", bus.data_out, dr[0]);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(wr[2], '0, dr[2], CE);
    send(wr[3], '0, dr[3], CE);
    drain();

    // Saturate ce_cnt with random single-symbol errors
    for (int k = 0; k < 20; k++) begin
      rd = {$urandom, $urandom};
      send(flip(encode(rd), int'($urandom_range(0, N-1)), 8'($urandom_range(1, 255))),
           '0, rd, CE);
    end
    drain();
    chk("sat_ce_cnt", {60'd0, ce_cnt}, 64'hF);
    chk("sat_ce_model", {60'd0, ce_cnt}, {60'd0, m_ce});

    // cnt_clr coincident with a CE handshake
    send(flip(cw0, 7, 8'h99), '0, d0, CE);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_ce_cnt", {60'd0, ce_cnt}, 64'd0);
    chk("clr_due_cnt", {60'd0, due_cnt}, 64'd0);
    drain();

    // Reset with two words in flight
    bus.out_ready = 1'b0;
    send(cw0, '0, d0, NE);
    send(flip(cw0, 3, 8'h01), '0, d0, CE);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    sb.delete();
    #20;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(flip(cw0, 6, 8'h42), '0, d0, CE);
    drain();
    chk("post_rst_ce_cnt", {60'd0, ce_cnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_erasure_decoder_pipe.md
# rs_erasure_decoder_pipe

Pipelined, parametrised rank-level RS decoder over GF(2^8) with two parity symbols (distance 3), generalising the 10/8 combinational decoder to NUM_DATA_SYM data symbols. It accepts one codeword per cycle under valid/ready handshakes. Per codeword it selects error or erasure correction from a per-symbol erasure mask and returns corrected data with an NE/CE/DUE status. It sits between the rank read-data path and the memory controller's response queue, and keeps saturating CE/DUE event counters for RAS logging.

## Interface
- NUM_DATA_SYM, 8, data symbols K; legal range 2..32; codeword N = K+2 symbols
- CNT_W, 16, width of each event counter
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  codeword/mask valid
- in_ready  output  1  block can accept this cycle
- codeword_in  input  8*N  symbol 0 at [8N-1 -: 8]; data symbols 0..K-1, then P0 (index K), then P1 (index K+1)
- erasure_mask_in  input  N  bit i set = symbol i is a known-bad chip; bit N-1 = symbol 0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- data_out  output  8*K  corrected (or raw on DUE) data symbols 0..K-1
- decode_result_out  output  2  00 NE, 01 CE, 10 DUE; 11 never produced
- ce_cnt  output  CNT_W  CE results delivered
- due_cnt  output  CNT_W  DUE results delivered
- cnt_clr  input  1  synchronous clear of both counters

## Operation
- Field: primitive polynomial x^8+x^4+x^3+x^2+1, alpha = 0x02.
- H rows: row0 = 1 for symbols 0..K-1, 1 for P0, 0 for P1. Row1 = alpha^i for data symbol i, 0 for P0, 1 for P1. Syndromes are S0 = XOR of symbols 0..K; S1 = XOR of alpha^i·sym_i for i < K, XOR P1.
- Mode select uses the erasure-mask popcount E.
- E=0, error mode:
  - S0=S1=0 -> NE
  - S0≠0, S1=0 -> P0 error, CE
  - S0=0, S1≠0 -> P1 error, CE
  - both ≠0 and S1 = alpha^j·S0 for some j<K -> flip symbol j by S0, CE
  - both ≠0 and no match -> DUE
- E=1, erasure at i:
  - S0=S1=0 -> NE
  - Otherwise the expected syndrome column for i is (h0_i, h1_i). If the syndrome is consistent with that column (S1 = h1_i·S0 with h0_i = 1, or S0 = 0 when h0_i = 0), correct symbol i by the error value and report CE; otherwise DUE.
- E=2, erasures at i<j: only when RS_DEC_DOUBLE_ERASURE_EN is defined; otherwise DUE.
  - Solve e_i·h_i + e_j·h_j = (S0,S1); det = h0_i·h1_j + h0_j·h1_i (always nonzero for distinct positions).
  - Both e = 0 -> NE; otherwise CE with both erased symbols corrected.
- E≥3 -> DUE.
- DUE: data_out = raw codeword data symbols, unmodified.
- Parity corrections never alter data_out but still report CE.
- Counters: on an output handshake (out_valid & out_ready), increment ce_cnt if the result is CE and due_cnt if it is DUE. Both saturate at all-ones. cnt_clr wins over a simultaneous increment; the counter becomes 0.

## Timing
- Two register stages:
  - S1 registers codeword, mask, S0, S1 and E.
  - S2 registers data_out and decode_result_out.
- Latency is 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 codeword/cycle.
- Stall handling: each stage advances when it is empty or the stage downstream advances. in_ready = !s1_valid | s1_advance, which is combinational from out_ready.
- Holds: out_valid, data_out and decode_result_out stay stable while out_valid & !out_ready. Ordering is strictly FIFO and nothing is dropped.
- Reset values: in_ready 0 while rst is asserted and 1 from the first cycle after release. out_valid 0, data_out 0, decode_result_out 00, ce_cnt 0, due_cnt 0.
- Reset mid-operation discards all in-flight codewords; no partial result emerges after release.

## Configuration
- RS_DEC_DOUBLE_ERASURE_EN defined: the E=2 solver (GF inverse of det plus multipliers) is compiled into S2 and two-erasure codewords are corrected.
- RS_DEC_DOUBLE_ERASURE_EN undefined: the solver is absent and E=2 yields DUE with raw data. Latency is unchanged.

## Test plan
- K=8, all-zero codeword, mask 0 -> NE, data_out 0, counters unchanged, out_valid exactly 2 cycles after input handshake.
- Valid codeword for data 0x0102..08, symbol 3 XOR 0x5A, mask 0 -> CE, original data restored, ce_cnt = 1.
- Same codeword with symbols 1 and 6 corrupted (0xFF, 0x11), mask bits for 1 and 6 set -> CE with exact data when RS_DEC_DOUBLE_ERASURE_EN is defined; DUE with raw corrupted data and due_cnt = 1 without it.
- Three mask bits set, or two random data symbol errors with mask 0 that produce a non-matching syndrome -> DUE, data_out equals the raw input data.
- Hold out_ready low for 6 cycles while driving 4 back-to-back codewords -> in_ready drops after 2 are accepted, outputs stay stable, and all 4 emerge in order once out_ready rises.
- Preload ce_cnt to all-ones via repeated CE with CNT_W=4 -> it stays 0xF. Assert cnt_clr on a CE handshake cycle -> ce_cnt becomes 0. Assert rst with 2 words in flight -> out_valid stays 0 after release.
